// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: enable levels and FSM states.
package irq_ctrl_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // IRQ_IDLE: nothing presented. IRQ_REQ: irq_id frozen and offered to the core.
  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_REQ  = 1'b1
  } irq_state_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// Bundle between the CP0 Status/Cause side, the pipeline and the interrupt controller.
interface irq_ctrl_if #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
);

  logic [NUM_SRC-1:0] src_i;
  logic [NUM_SRC-1:0] sw_set;
  logic [NUM_SRC-1:0] im;
  logic               ie;
  logic               ack;
  logic               eoi;
  logic               irq_o;
  logic [ID_W-1:0]    irq_id;
  logic [NUM_SRC-1:0] ip;
  logic [NUM_SRC-1:0] isr;

  // Core/CP0 side drives requests, masks and handshake pulses.
  modport master (
    output src_i, sw_set, im, ie, ack, eoi,
    input  irq_o, irq_id, ip, isr
  );

  // Controller side.
  modport slave (
    input  src_i, sw_set, im, ie, ack, eoi,
    output irq_o, irq_id, ip, isr
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Priority encoder: reports whether any bit is set and the index of the highest one.
module irq_prio_enc #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic [NUM_SRC-1:0] vec,
  output logic               vld,
  output logic [ID_W-1:0]    id
);

  // Scan upward so the last (highest) set index wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise an all-zero
    // input would leave id unassigned and infer a latch.
    vld = 1'b0;
    id  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (vec[i]) begin
        vld = 1'b1;
        id  = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: pending latch, masking, nested in-service tracking and a
// registered request/acknowledge handshake towards the core.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int                 NUM_SRC   = 8,
  parameter int                 ID_W      = 3,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = NUM_SRC'(8'b1100_0000)
) (
  input  logic     clk,
  input  logic     rst,
  irq_ctrl_if.slave bus
);

  irq_state_e         state, state_next;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] ip_q, ip_next;
  logic [NUM_SRC-1:0] isr_q, isr_next;
  logic               irq_q, irq_d;
  logic [ID_W-1:0]    id_q, id_d;

  logic [NUM_SRC-1:0] rise, set, clr, cand;
  logic               c_vld, s_vld;
  logic [ID_W-1:0]    c_id, s_id;
  logic               go, go_frozen, take;

  assign rise = bus.src_i & ~src_q;
  assign set  = ((EDGE_MASK & rise) | (~EDGE_MASK & bus.src_i)) | bus.sw_set;
  assign cand = ip_q & bus.im;
  assign take = bus.ack && (state == IRQ_REQ);

  irq_prio_enc #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_cand_enc (
    .vec (cand),
    .vld (c_vld),
    .id  (c_id)
  );

  irq_prio_enc #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_isr_enc (
    .vec (isr_q),
    .vld (s_vld),
    .id  (s_id)
  );

  // Only a strictly higher priority than anything in service may be presented.
  assign go        = bus.ie && c_vld && (!s_vld || (c_id > s_id));
  assign go_frozen = bus.ie && cand[id_q];

  // Pending bits: set terms win over the acknowledge clear so held levels re-pend.
  always_comb begin
    clr = '0;
    if (take) clr[id_q] = 1'b1;
    ip_next = set | (ip_q & ~clr);
  end

  // In-service bits: end-of-interrupt retires the top level before ack adds one.
  always_comb begin
    isr_next = isr_q;
    if (bus.eoi && s_vld) isr_next[s_id] = 1'b0;
    if (take)             isr_next[id_q] = 1'b1;
  end

  // Handshake FSM next state; irq_id is captured on entry to IRQ_REQ and held.
  always_comb begin
    state_next = state;
    irq_d      = DISABLE;
    id_d       = id_q;
    case (state)
      IRQ_IDLE: begin
        if (go) begin
          state_next = IRQ_REQ;
          irq_d      = ENABLE;
          id_d       = c_id;
        end
      end
      IRQ_REQ: begin
        irq_d = ENABLE;
        if (bus.ack || !go_frozen) begin
          state_next = IRQ_IDLE;
          irq_d      = DISABLE;
        end
      end
    endcase
  end

  // State register; synchronous reset clears everything on the reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IRQ_IDLE;
      src_q <= '0;
      ip_q  <= '0;
      isr_q <= '0;
      irq_q <= DISABLE;
      id_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      src_q <= bus.src_i;
      ip_q  <= ip_next;
      isr_q <= isr_next;
      irq_q <= irq_d;
      id_q  <= id_d;
    end
  end

  assign bus.irq_o  = irq_q;
  assign bus.irq_id = id_q;
  assign bus.ip     = ip_q;
  assign bus.isr    = isr_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a cycle table for the basic flows plus hand-written
// sequences for nesting, frozen ID, enable drop and reset during a request.
module tb_irq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  irq_ctrl_if #(.NUM_SRC(8), .ID_W(3)) ifc ();

  irq_ctrl #(.NUM_SRC(8), .ID_W(3), .EDGE_MASK(8'b1100_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] src;
    logic [7:0] sw;
    logic [7:0] im;
    logic       ie;
    logic       ack;
    logic       eoi;
    logic       e_irq;
    logic       chk_id;
    logic [2:0] e_id;
    logic [7:0] e_ip;
    logic [7:0] e_isr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [7:0] src, logic [7:0] sw, logic [7:0] im,
                              logic ie, logic ack, logic eoi, logic e_irq, logic chk_id,
                              logic [2:0] e_id, logic [7:0] e_ip, logic [7:0] e_isr);
    vec_t v;
    v.rst = r;  v.src = src; v.sw = sw; v.im = im; v.ie = ie; v.ack = ack; v.eoi = eoi;
    v.e_irq = e_irq; v.chk_id = chk_id; v.e_id = e_id; v.e_ip = e_ip; v.e_isr = e_isr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, clock it, and settle just after the edge.
  task automatic cyc(input logic r, input logic [7:0] src, input logic [7:0] sw,
                     input logic [7:0] im, input logic ie, input logic ack, input logic eoi);
    rst        = r;
    ifc.src_i  = src;
    ifc.sw_set = sw;
    ifc.im     = im;
    ifc.ie     = ie;
    ifc.ack    = ack;
    ifc.eoi    = eoi;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic e_irq, input logic chk_id,
                            input logic [2:0] e_id, input logic [7:0] e_ip, input logic [7:0] e_isr);
    check({tag, ".irq_o"}, 32'(ifc.irq_o), 32'(e_irq));
    if (chk_id) check({tag, ".irq_id"}, 32'(ifc.irq_id), 32'(e_id));
    check({tag, ".ip"}, 32'(ifc.ip), 32'(e_ip));
    check({tag, ".isr"}, 32'(ifc.isr), 32'(e_isr));
  endtask

  initial begin
    ifc.src_i = '0; ifc.sw_set = '0; ifc.im = '0; ifc.ie = 1'b0; ifc.ack = 1'b0; ifc.eoi = 1'b0;

    //                 rst src    sw     im     ie ack eoi  irq cid id  ip     isr
    vecs.push_back(mk(1, 8'h00, 8'h00, 8'hFF, 1, 0, 0,   0, 1, 0, 8'h00, 8'h00)); // reset
    vecs.push_back(mk(0, 8'h80, 8'h00, 8'hFF, 1, 0, 0,   0, 0, 0, 8'h80, 8'h00)); // timer edge
    vecs.push_back(mk(0, 8'h80, 8'h00, 8'hFF, 1, 0, 0,   1, 1, 7, 8'h80, 8'h00)); // request 7
    vecs.push_back(mk(0, 8'h00, 8'h00, 8'hFF, 1, 1, 0,   0, 0, 0, 8'h00, 8'h80)); // ack 7
    vecs.push_back(mk(0, 8'h00, 8'h00, 8'hFF, 1, 0, 1,   0, 0, 0, 8'h00, 8'h00)); // eoi 7
    vecs.push_back(mk(0, 8'h08, 8'h00, 8'hFF, 1, 0, 0,   0, 0, 0, 8'h08, 8'h00)); // level 3
    vecs.push_back(mk(0, 8'h08, 8'h00, 8'hFF, 1, 0, 0,   1, 1, 3, 8'h08, 8'h00)); // request 3
    vecs.push_back(mk(0, 8'h08, 8'h00, 8'hFF, 1, 1, 0,   0, 0, 0, 8'h08, 8'h08)); // ack, re-pend
    vecs.push_back(mk(0, 8'h08, 8'h00, 8'hFF, 1, 0, 0,   0, 0, 0, 8'h08, 8'h08)); // blocked
    vecs.push_back(mk(0, 8'h08, 8'h00, 8'hFF, 1, 0, 1,   0, 0, 0, 8'h08, 8'h00)); // eoi 3
    vecs.push_back(mk(0, 8'h08, 8'h00, 8'hFF, 1, 0, 0,   1, 1, 3, 8'h08, 8'h00)); // re-request 3
    vecs.push_back(mk(0, 8'h00, 8'h00, 8'hFF, 1, 1, 0,   0, 0, 0, 8'h00, 8'h08)); // ack, line low
    vecs.push_back(mk(0, 8'h00, 8'h00, 8'hFF, 1, 0, 1,   0, 0, 0, 8'h00, 8'h00)); // eoi 3
    vecs.push_back(mk(0, 8'h00, 8'h02, 8'hFF, 1, 0, 0,   0, 0, 0, 8'h02, 8'h00)); // sw_set 1
    vecs.push_back(mk(0, 8'h00, 8'h00, 8'hFF, 1, 0, 0,   1, 1, 1, 8'h02, 8'h00)); // request 1
    vecs.push_back(mk(0, 8'h00, 8'h00, 8'hFD, 1, 0, 0,   0, 0, 0, 8'h02, 8'h00)); // masked, withdraw
    vecs.push_back(mk(0, 8'h00, 8'h00, 8'hFF, 1, 0, 0,   1, 1, 1, 8'h02, 8'h00)); // unmasked
    vecs.push_back(mk(0, 8'h00, 8'h02, 8'hFF, 1, 1, 0,   0, 0, 0, 8'h02, 8'h02)); // sw_set vs clear
    vecs.push_back(mk(0, 8'h00, 8'h00, 8'hFF, 1, 0, 0,   0, 0, 0, 8'h02, 8'h02)); // blocked
    vecs.push_back(mk(0, 8'h00, 8'h00, 8'hFF, 1, 0, 1,   0, 0, 0, 8'h02, 8'h00)); // eoi 1
    vecs.push_back(mk(0, 8'h00, 8'h00, 8'hFF, 1, 0, 0,   1, 1, 1, 8'h02, 8'h00)); // request 1
    vecs.push_back(mk(0, 8'h00, 8'h00, 8'hFF, 1, 1, 0,   0, 0, 0, 8'h00, 8'h02)); // ack 1
    vecs.push_back(mk(0, 8'h00, 8'h00, 8'hFF, 1, 0, 1,   0, 0, 0, 8'h00, 8'h00)); // eoi 1
    vecs.push_back(mk(0, 8'h00, 8'h00, 8'hFF, 1, 1, 1,   0, 0, 0, 8'h00, 8'h00)); // stray ack+eoi

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].src, vecs[i].sw, vecs[i].im, vecs[i].ie, vecs[i].ack, vecs[i].eoi);
      expect_out($sformatf("vec%0d", i), vecs[i].e_irq, vecs[i].chk_id, vecs[i].e_id,
                 vecs[i].e_ip, vecs[i].e_isr);
    end

    // Nesting: 6 in service, 7 preempts, software 1 waits for two eoi pulses.
    cyc(0, 8'h40, 8'h00, 8'hFF, 1, 0, 0); expect_out("nest.pend6", 0, 0, 0, 8'h40, 8'h00);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 0, 0); expect_out("nest.req6",  1, 1, 6, 8'h40, 8'h00);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 1, 0); expect_out("nest.ack6",  0, 0, 0, 8'h00, 8'h40);
    cyc(0, 8'h80, 8'h02, 8'hFF, 1, 0, 0); expect_out("nest.pend",  0, 0, 0, 8'h82, 8'h40);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 0, 0); expect_out("nest.req7",  1, 1, 7, 8'h82, 8'h40);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 1, 0); expect_out("nest.ack7",  0, 0, 0, 8'h02, 8'hC0);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 0, 0); expect_out("nest.wait",  0, 0, 0, 8'h02, 8'hC0);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 0, 1); expect_out("nest.eoi1",  0, 0, 0, 8'h02, 8'h40);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 0, 0); expect_out("nest.hold",  0, 0, 0, 8'h02, 8'h40);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 0, 1); expect_out("nest.eoi2",  0, 0, 0, 8'h02, 8'h00);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 0, 0); expect_out("nest.req1",  1, 1, 1, 8'h02, 8'h00);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 1, 0); expect_out("nest.ack1",  0, 0, 0, 8'h00, 8'h02);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 0, 1); expect_out("nest.eoi3",  0, 0, 0, 8'h00, 8'h00);

    // Frozen ID: 7 arrives while 6 is presented; 6 stays until ack.
    cyc(0, 8'h40, 8'h00, 8'hFF, 1, 0, 0); expect_out("frz.pend6",  0, 0, 0, 8'h40, 8'h00);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 0, 0); expect_out("frz.req6",   1, 1, 6, 8'h40, 8'h00);
    cyc(0, 8'h80, 8'h00, 8'hFF, 1, 0, 0); expect_out("frz.arr7",   1, 1, 6, 8'hC0, 8'h00);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 0, 0); expect_out("frz.hold",   1, 1, 6, 8'hC0, 8'h00);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 1, 0); expect_out("frz.ack6",   0, 0, 0, 8'h80, 8'h40);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 0, 0); expect_out("frz.req7",   1, 1, 7, 8'h80, 8'h40);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 1, 0); expect_out("frz.ack7",   0, 0, 0, 8'h00, 8'hC0);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 0, 1); expect_out("frz.eoi7",   0, 0, 0, 8'h00, 8'h40);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 0, 1); expect_out("frz.eoi6",   0, 0, 0, 8'h00, 8'h00);

    // Global enable dropped during a request withdraws it; restoring re-requests.
    cyc(0, 8'h40, 8'h00, 8'hFF, 1, 0, 0); expect_out("ie.pend6",   0, 0, 0, 8'h40, 8'h00);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 0, 0); expect_out("ie.req6",    1, 1, 6, 8'h40, 8'h00);
    cyc(0, 8'h00, 8'h00, 8'hFF, 0, 0, 0); expect_out("ie.drop",    0, 0, 0, 8'h40, 8'h00);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 0, 0); expect_out("ie.restore", 1, 1, 6, 8'h40, 8'h00);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 1, 0); expect_out("ie.ack6",    0, 0, 0, 8'h00, 8'h40);

    // Reset while a request is up with 6 in service; a following ack is inert.
    cyc(0, 8'h80, 8'h00, 8'hFF, 1, 0, 0); expect_out("rst.pend7",  0, 0, 0, 8'h80, 8'h40);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 0, 0); expect_out("rst.req7",   1, 1, 7, 8'h80, 8'h40);
    cyc(1, 8'h00, 8'h00, 8'hFF, 1, 0, 0); expect_out("rst.clear",  0, 1, 0, 8'h00, 8'h00);
    cyc(0, 8'h00, 8'h00, 8'hFF, 1, 1, 0); expect_out("rst.ack",    0, 1, 0, 8'h00, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
